// File: rtl/fifo_packer_pkg.sv
// fifo_packer_pkg
// Shared constants and helpers for the fifo_packer stream width up-converter.
// Optional feature macro: FIFO_PACKER_EOT_EN. When it is defined, each stream
// word carries one extra end-of-transfer flag bit above its data bits.
// No ports (package).
package fifo_packer_pkg;

`ifdef FIFO_PACKER_EOT_EN
  localparam int EOT_BITS = 1;
`else
  localparam int EOT_BITS = 0;
`endif

  // Width of the lane counter for a given packing ratio.
  function automatic int cnt_width(input int ratio);
    return $clog2(ratio);
  endfunction

  // The EOT flag sits directly above the data bits on each side.
  function automatic int eot_in_pos(input int in_width);
    return in_width;
  endfunction

  function automatic int eot_out_pos(input int in_width, input int ratio);
    return in_width * ratio;
  endfunction

endpackage

// File: rtl/fifo_packer_if.sv
// fifo_packer_if
// Bundles the upstream FIFO read side and the downstream write side of the
// packer. Optional feature macro: FIFO_PACKER_EOT_EN (adds one flag bit to
// s_dout and m_din through EOT_BITS).
// Signals:
//   s_empty_n  upstream FIFO holds a word
//   s_read     consume the head word this cycle
//   s_dout     head word (data, plus EOT flag when enabled)
//   m_full_n   downstream can accept a word this cycle
//   m_write    write m_din this cycle
//   m_din      packed word (data, plus EOT flag when enabled)
// Modports: master = the packer, slave = the surrounding FIFOs.
interface fifo_packer_if #(
  parameter int IN_WIDTH = 32,
  parameter int RATIO    = 4
);
  import fifo_packer_pkg::*;

  localparam int S_W = IN_WIDTH + EOT_BITS;
  localparam int M_W = IN_WIDTH * RATIO + EOT_BITS;

  logic           s_empty_n;
  logic           s_read;
  logic [S_W-1:0] s_dout;
  logic           m_full_n;
  logic           m_write;
  logic [M_W-1:0] m_din;

  modport master (
    input  s_empty_n, s_dout, m_full_n,
    output s_read, m_write, m_din
  );

  modport slave (
    output s_empty_n, s_dout, m_full_n,
    input  s_read, m_write, m_din
  );

endinterface

// File: rtl/fifo_packer.sv
// fifo_packer
// Drains narrow words from a first-word fall-through FIFO and packs RATIO
// consecutive words into one wide word (first word in the lowest lane).
// Sustains one input word per cycle while the output is not back-pressured.
// Optional feature macro: FIFO_PACKER_EOT_EN enables end-of-transfer handling:
// a pending partial word is flushed zero-padded, then one EOT word is emitted.
// Ports:
//   clk      sole clock, rising edge
//   reset_n  asynchronous active-low reset
//   bus      fifo_packer_if.master (s_empty_n/s_read/s_dout, m_full_n/m_write/m_din)
module fifo_packer
  import fifo_packer_pkg::*;
#(
  parameter int IN_WIDTH = 32,
  parameter int RATIO    = 4
) (
  input logic           clk,
  input logic           reset_n,
  fifo_packer_if.master bus
);

  localparam int OUT_WIDTH = IN_WIDTH * RATIO;
  localparam int CNT_W     = cnt_width(RATIO);
  localparam int M_W       = OUT_WIDTH + EOT_BITS;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(RATIO - 1);

  logic [CNT_W-1:0]               cnt;
  logic [CNT_W-1:0]               cnt_d;
  logic [RATIO-2:0][IN_WIDTH-1:0] lanes;
  logic [M_W-1:0]                 out_q;
  logic [M_W-1:0]                 load_val;
  logic                           out_v;
  logic                           load;
  logic                           lane_we;
  logic                           out_free;
  logic                           s_read;
  logic                           eot_head;
  logic [IN_WIDTH-1:0]            s_data;

  assign s_data = bus.s_dout[IN_WIDTH-1:0];

  // out_q can take a new word if it is empty or is being written this cycle.
  assign out_free    = ~out_v | bus.m_full_n;
  assign bus.m_write = out_v & bus.m_full_n;
  assign bus.m_din   = out_q;
  assign bus.s_read  = s_read;

`ifdef FIFO_PACKER_EOT_EN
  localparam int EOT_IN_POS  = eot_in_pos(IN_WIDTH);
  localparam int EOT_OUT_POS = eot_out_pos(IN_WIDTH, RATIO);
  assign eot_head = bus.s_empty_n & bus.s_dout[EOT_IN_POS];
`else
  assign eot_head = 1'b0;
`endif

  always_comb begin
    cnt_d    = cnt;
    load     = 1'b0;
    lane_we  = 1'b0;
    load_val = '0;
    s_read   = 1'b0;
    if (!eot_head) begin
      // Only the completing lane depends on out_q having room.
      s_read = bus.s_empty_n & ((cnt != LAST) | out_free);
      if (s_read) begin
        if (cnt == LAST) begin
          load                     = 1'b1;
          cnt_d                    = '0;
          load_val[OUT_WIDTH-1:0]  = {s_data, lanes};
        end else begin
          lane_we = 1'b1;
          cnt_d   = cnt + CNT_W'(1);
        end
      end
    end
`ifdef FIFO_PACKER_EOT_EN
    else if (out_free) begin
      load  = 1'b1;
      cnt_d = '0;
      if (cnt == '0) begin
        // Lane boundary: consume the EOT word and emit the flag word.
        s_read                = 1'b1;
        load_val[EOT_OUT_POS] = 1'b1;
      end else begin
        // Partial flush: EOT stays at the head and is read next cycle.
        // Lanes at or above cnt hold stale data and are zeroed here.
        for (int k = 0; k < RATIO - 1; k++) begin
          if (CNT_W'(k) < cnt) begin
            load_val[k*IN_WIDTH +: IN_WIDTH] = lanes[k];
          end
        end
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt   <= '0;
      out_v <= 1'b0;
      out_q <= '0;
      lanes <= '0;
    end else begin
      cnt <= cnt_d;
      // A load in the same cycle as a write keeps out_v set.
      if (load) begin
        out_q <= load_val;
        out_v <= 1'b1;
      end else if (bus.m_full_n) begin
        out_v <= 1'b0;
      end
      for (int k = 0; k < RATIO - 1; k++) begin
        if (lane_we && (cnt == CNT_W'(k))) begin
          lanes[k] <= s_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_packer.sv
// tb_fifo_packer
// Self-checking bench for fifo_packer (IN_WIDTH=32, RATIO=4). A queue-based
// reference model tracks pending input words and packed output words; every
// cycle s_read, m_write and m_din are compared against it, alongside directed
// checks of the documented scenarios. EOT scenarios run when
// FIFO_PACKER_EOT_EN is defined.
module tb_fifo_packer;
  import fifo_packer_pkg::*;

  localparam int IN_W    = 32;
  localparam int RATIO_P = 4;
  localparam int OUT_W   = IN_W * RATIO_P;
  localparam int S_W     = IN_W + EOT_BITS;

  typedef logic [255:0]   wide_t;
  typedef logic [S_W-1:0] word_t;

  logic clk = 1'b0;
  logic reset_n;

  fifo_packer_if #(.IN_WIDTH(IN_W), .RATIO(RATIO_P)) bus ();

  fifo_packer #(.IN_WIDTH(IN_W), .RATIO(RATIO_P)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  word_t             src_q[$];
  logic [IN_W-1:0]   pend[$];
  wide_t             exp_q[$];
  wide_t             wr_log[$];
  logic              obs_read;
  logic              obs_write;
  wide_t             obs_din;
  int                n_writes    = 0;
  int                n_eot_reads = 0;

  task automatic check_output(input string tag, input wide_t observed, input wide_t expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic word_t make_word(input bit eot, input logic [IN_W-1:0] data);
    word_t w;
    w = '0;
    w[IN_W-1:0] = data;
`ifdef FIFO_PACKER_EOT_EN
    w[IN_W] = eot;
`endif
    return w;
  endfunction

  function automatic bit is_eot(input word_t w);
`ifdef FIFO_PACKER_EOT_EN
    return w[IN_W];
`else
    return 1'b0;
`endif
  endfunction

  function automatic wide_t pack_pend();
    wide_t r;
    r = '0;
    foreach (pend[k]) r[k*IN_W +: IN_W] = pend[k];
    return r;
  endfunction

  // One clock cycle: present the head of src_q, then at the falling edge
  // compare the DUT against the model and advance the model.
  task automatic apply_stimulus(input bit gate, input bit full_n);
    bit present, head_eot, occupied, free_slot, exp_read, exp_write, flush;
    bus.m_full_n  = full_n;
    present       = gate && (src_q.size() > 0);
    bus.s_empty_n = present;
    bus.s_dout    = present ? src_q[0] : '0;
    @(negedge clk);
    obs_read  = bus.s_read;
    obs_write = bus.m_write;
    obs_din   = wide_t'(bus.m_din);
    head_eot  = present && is_eot(src_q[0]);
    occupied  = exp_q.size() > 0;
    free_slot = !occupied || full_n;
    exp_write = occupied && full_n;
    if (head_eot) begin
      exp_read = (pend.size() == 0) && free_slot;
      flush    = (pend.size() != 0) && free_slot;
    end else begin
      exp_read = present && ((pend.size() != RATIO_P - 1) || free_slot);
      flush    = 1'b0;
    end
    check_output("s_read", obs_read, exp_read);
    check_output("m_write", obs_write, exp_write);
    if (obs_write === 1'b1) begin
      n_writes++;
      wr_log.push_back(obs_din);
    end
    if (obs_read === 1'b1 && head_eot) n_eot_reads++;
    if (exp_write) begin
      check_output("m_din", obs_din, exp_q[0]);
      void'(exp_q.pop_front());
    end
    if (flush) begin
      exp_q.push_back(pack_pend());
      pend.delete();
    end
    if (exp_read) begin
      word_t w;
      w = src_q.pop_front();
      if (is_eot(w)) begin
        wide_t e;
        e = '0;
        e[OUT_W] = 1'b1;
        exp_q.push_back(e);
      end else begin
        pend.push_back(w[IN_W-1:0]);
        if (pend.size() == RATIO_P) begin
          exp_q.push_back(pack_pend());
          pend.delete();
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse, checked before any clock edge can act.
  task automatic pulse_reset();
    bus.s_empty_n = 1'b0;
    bus.m_full_n  = 1'b1;
    reset_n       = 1'b0;
    #1;
    check_output("rst_s_read", bus.s_read, 0);
    check_output("rst_m_write", bus.m_write, 0);
    check_output("rst_m_din", wide_t'(bus.m_din), 0);
    src_q.delete();
    pend.delete();
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int base;
    wide_t eot_word;
    eot_word = '0;
    eot_word[OUT_W] = 1'b1;

    reset_n       = 1'b1;
    bus.s_empty_n = 1'b0;
    bus.m_full_n  = 1'b1;
    bus.s_dout    = '0;
    #1;
    pulse_reset();

    $display("[TB] basic pack");
    for (int i = 1; i <= 4; i++) src_q.push_back(make_word(0, 32'(i * 32'h11)));
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1, 1);
      check_output("t1_read", obs_read, 1);
      check_output("t1_no_write", obs_write, 0);
    end
    apply_stimulus(1, 1);
    check_output("t1_write", obs_write, 1);
    check_output("t1_din", obs_din, wide_t'(128'h00000044_00000033_00000022_00000011));

    $display("[TB] continuous stream");
    base = n_writes;
    for (int i = 1; i <= 8; i++) src_q.push_back(make_word(0, 32'(32'h100 + i)));
    for (int i = 0; i < 8; i++) begin
      apply_stimulus(1, 1);
      check_output("t2_read", obs_read, 1);
    end
    apply_stimulus(1, 1);
    check_output("t2_writes", n_writes - base, 2);

    $display("[TB] back-pressure");
    for (int i = 1; i <= 4; i++) src_q.push_back(make_word(0, 32'(32'h200 + i)));
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1, 0);
      check_output("t3_read_a", obs_read, 1);
    end
    for (int i = 1; i <= 4; i++) src_q.push_back(make_word(0, 32'(32'h300 + i)));
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1, 0);
      check_output("t3_read_b", obs_read, 1);
    end
    for (int i = 0; i < 3; i++) begin
      apply_stimulus(1, 0);
      check_output("t3_stall_read", obs_read, 0);
      check_output("t3_stall_write", obs_write, 0);
    end
    apply_stimulus(1, 1);
    check_output("t3_reload_read", obs_read, 1);
    check_output("t3_drain_write", obs_write, 1);
    check_output("t3_din_a", obs_din, wide_t'(128'h00000204_00000203_00000202_00000201));
    apply_stimulus(1, 1);
    check_output("t3_write_b", obs_write, 1);
    check_output("t3_din_b", obs_din, wide_t'(128'h00000304_00000303_00000302_00000301));

    $display("[TB] reset mid-word");
    for (int i = 1; i <= 4; i++) src_q.push_back(make_word(0, 32'(32'h400 + i)));
    apply_stimulus(1, 1);
    apply_stimulus(1, 1);
    pulse_reset();
    for (int i = 1; i <= 4; i++) src_q.push_back(make_word(0, 32'(32'h500 + i)));
    for (int i = 0; i < 4; i++) apply_stimulus(1, 1);
    apply_stimulus(1, 1);
    check_output("t4_write", obs_write, 1);
    check_output("t4_din", obs_din, wide_t'(128'h00000504_00000503_00000502_00000501));

    $display("[TB] random traffic");
    for (int c = 0; c < 400; c++) begin
      while (src_q.size() < 4) src_q.push_back(make_word(0, $urandom));
      apply_stimulus($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    end
    for (int c = 0; c < 10; c++) apply_stimulus(0, 1);
    check_output("rand_drained", exp_q.size(), 0);

`ifdef FIFO_PACKER_EOT_EN
    $display("[TB] EOT after partial word");
    pulse_reset();
    for (int i = 1; i <= 4; i++) src_q.push_back(make_word(0, 32'(32'hF0 + i)));
    for (int i = 0; i < 5; i++) apply_stimulus(1, 1);
    base = wr_log.size();
    n_eot_reads = 0;
    src_q.push_back(make_word(0, 32'hA));
    src_q.push_back(make_word(0, 32'hB));
    src_q.push_back(make_word(1, $urandom));
    for (int i = 0; i < 7; i++) apply_stimulus(1, 1);
    check_output("e1_writes", wr_log.size() - base, 2);
    check_output("e1_partial", wr_log[base], wide_t'(128'h0B_0000000A));
    check_output("e1_eot", wr_log[base + 1], eot_word);
    check_output("e1_eot_reads", n_eot_reads, 1);

    $display("[TB] EOT on lane boundary");
    base = wr_log.size();
    n_eot_reads = 0;
    for (int i = 1; i <= 4; i++) src_q.push_back(make_word(0, 32'(32'hC0 + i)));
    src_q.push_back(make_word(1, $urandom));
    for (int i = 0; i < 8; i++) apply_stimulus(1, 1);
    check_output("e2_writes", wr_log.size() - base, 2);
    check_output("e2_full", wr_log[base], wide_t'(128'h000000C4_000000C3_000000C2_000000C1));
    check_output("e2_eot", wr_log[base + 1], eot_word);
    check_output("e2_eot_reads", n_eot_reads, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
